// File: rtl/if_id_reg.sv
// if_id_reg: IF -> D pipeline register.
//
// Captures the fetched instruction and its PC on each rising clock edge.
// Presents them to the D stage together with:
//   - a valid flag,
//   - a branch-delay-slot flag,
//   - a fetch address-error code for CP0.
// Every output comes straight from a flop. No input reaches an output combinationally.
//
// Edge priority: Flush_D > stall (!En_D) > branch-likely annul > normal load.
//
// Optional feature: `BRANCH_LIKELY_EN
//   Defined:   Branch_Annul_D turns a load into a bubble that still carries PC_F.
//   Undefined: Branch_Annul_D is ignored.
//
// Ports:
//   clk             in   1   clock, rising edge
//   reset           in   1   asynchronous, active-high reset
//   En_D            in   1   1 = load from F, 0 = stall (hold every output)
//   Flush_D         in   1   load a bubble (exception / eret)
//   Branch_Annul_D  in   1   annul the delay slot of a not-taken branch-likely
//   Is_Branch_D     in   1   instruction now in D has a delay slot
//   Instr_F         in   32  fetched instruction word
//   PC_F            in   32  fetch PC
//   Instr_D         out  32  instruction to D stage
//   PC_D            out  32  PC of Instr_D
//   PC8_D           out  32  PC_D + 8 (link address)
//   Valid_D         out  1   Instr_D is architecturally live
//   BD_D            out  1   Instr_D sits in a branch delay slot
//   ExcCode_D       out  5   5'd4 = AdEL on fetch, 5'd0 = none
module if_id_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] TEXT_LO  = 32'h0000_3000,
  parameter logic [31:0] TEXT_HI  = 32'h0000_4FFC,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        En_D,
  input  logic        Flush_D,
  input  logic        Branch_Annul_D,
  input  logic        Is_Branch_D,
  input  logic [31:0] Instr_F,
  input  logic [31:0] PC_F,
  output logic [31:0] Instr_D,
  output logic [31:0] PC_D,
  output logic [31:0] PC8_D,
  output logic        Valid_D,
  output logic        BD_D,
  output logic [4:0]  ExcCode_D
);

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc8_q, pc8_d;
  logic        valid_q, valid_d;
  logic        bd_q, bd_d;
  logic [4:0]  exc_q, exc_d;

  logic [31:0] pc8_f;
  logic        fetch_adel;
  logic        annul;

  // Link address wraps modulo 2^32; the carry out is deliberately dropped.
  assign pc8_f = PC_F + 32'd8;

  // Misaligned or outside the text segment (unsigned compares).
  assign fetch_adel = (PC_F[1:0] != 2'b00) || (PC_F < TEXT_LO) || (PC_F > TEXT_HI);

`ifdef BRANCH_LIKELY_EN
  assign annul = Branch_Annul_D;
`else
  logic unused_branch_annul;
  assign unused_branch_annul = Branch_Annul_D;
  assign annul = 1'b0;
`endif

  always_comb begin
    // Default: hold (stall).
    instr_d = instr_q;
    pc_d    = pc_q;
    pc8_d   = pc8_q;
    valid_d = valid_q;
    bd_d    = bd_q;
    exc_d   = exc_q;

    if (Flush_D) begin
      // Bubble that still records the fetch PC.
      instr_d = NOP;
      pc_d    = PC_F;
      pc8_d   = pc8_f;
      valid_d = 1'b0;
      bd_d    = 1'b0;
      exc_d   = EXC_NONE;
    end else if (En_D) begin
      pc_d  = PC_F;
      pc8_d = pc8_f;
      if (annul) begin
        // Annulled delay slot never executes, so a fetch fault on it is moot.
        instr_d = NOP;
        valid_d = 1'b0;
        bd_d    = 1'b0;
        exc_d   = EXC_NONE;
      end else if (fetch_adel) begin
        // Stay valid so the fault travels down to M with its PC and BD for EPC.
        instr_d = NOP;
        valid_d = 1'b1;
        bd_d    = Is_Branch_D;
        exc_d   = EXC_ADEL;
      end else begin
        instr_d = Instr_F;
        valid_d = 1'b1;
        bd_d    = Is_Branch_D;
        exc_d   = EXC_NONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q <= NOP;
      pc_q    <= RESET_PC;
      pc8_q   <= RESET_PC + 32'd8;
      valid_q <= 1'b0;
      bd_q    <= 1'b0;
      exc_q   <= EXC_NONE;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      pc8_q   <= pc8_d;
      valid_q <= valid_d;
      bd_q    <= bd_d;
      exc_q   <= exc_d;
    end
  end

  assign Instr_D   = instr_q;
  assign PC_D      = pc_q;
  assign PC8_D     = pc8_q;
  assign Valid_D   = valid_q;
  assign BD_D      = bd_q;
  assign ExcCode_D = exc_q;

endmodule

// File: tb/tb_if_id_reg.sv
// Directed self-checking bench for if_id_reg.
// Expected values are hand-computed.
// The annul case expects different results depending on `BRANCH_LIKELY_EN.
module tb_if_id_reg;

  logic        clk;
  logic        reset;
  logic        En_D;
  logic        Flush_D;
  logic        Branch_Annul_D;
  logic        Is_Branch_D;
  logic [31:0] Instr_F;
  logic [31:0] PC_F;
  logic [31:0] Instr_D;
  logic [31:0] PC_D;
  logic [31:0] PC8_D;
  logic        Valid_D;
  logic        BD_D;
  logic [4:0]  ExcCode_D;

  int checks = 0;
  int errors = 0;

  if_id_reg dut (
    .clk           (clk),
    .reset         (reset),
    .En_D          (En_D),
    .Flush_D       (Flush_D),
    .Branch_Annul_D(Branch_Annul_D),
    .Is_Branch_D   (Is_Branch_D),
    .Instr_F       (Instr_F),
    .PC_F          (PC_F),
    .Instr_D       (Instr_D),
    .PC_D          (PC_D),
    .PC8_D         (PC8_D),
    .Valid_D       (Valid_D),
    .BD_D          (BD_D),
    .ExcCode_D     (ExcCode_D)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                           input logic [31:0] pc8, input logic valid, input logic bd,
                           input logic [4:0] exc);
    check({tag, ".instr"}, Instr_D, instr);
    check({tag, ".pc"}, PC_D, pc);
    check({tag, ".pc8"}, PC8_D, pc8);
    check({tag, ".valid"}, {31'd0, Valid_D}, {31'd0, valid});
    check({tag, ".bd"}, {31'd0, BD_D}, {31'd0, bd});
    check({tag, ".exc"}, {27'd0, ExcCode_D}, {27'd0, exc});
  endtask

  // Advance one edge and sample 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic flush, input logic annul, input logic br,
                       input logic [31:0] pc, input logic [31:0] instr);
    En_D           = en;
    Flush_D        = flush;
    Branch_Annul_D = annul;
    Is_Branch_D    = br;
    PC_F           = pc;
    Instr_F        = instr;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_3000, 32'h3C01_1234);
    tick();
    tick();
    check_all("reset", 32'h0, 32'h3000, 32'h3008, 1'b0, 1'b0, 5'd0);

    reset = 1'b0;
    tick();
    check_all("load1", 32'h3C01_1234, 32'h3000, 32'h3008, 1'b1, 1'b0, 5'd0);

    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_3004, 32'h1022_0003);
    tick();
    check_all("branch", 32'h1022_0003, 32'h3004, 32'h300C, 1'b1, 1'b1, 5'd0);

    // Stall: changed inputs and an annul request must all be ignored.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_3008, 32'hAAAA_5555);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all("stall", 32'h1022_0003, 32'h3004, 32'h300C, 1'b1, 1'b1, 5'd0);
    end

    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_3002, 32'h1234_5678);
    tick();
    check_all("misalign", 32'h0, 32'h3002, 32'h300A, 1'b1, 1'b0, 5'd4);

    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_5000, 32'h1234_5678);
    tick();
    check_all("above_hi", 32'h0, 32'h5000, 32'h5008, 1'b1, 1'b0, 5'd4);

    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_4FFC, 32'h2442_0001);
    tick();
    check_all("at_hi", 32'h2442_0001, 32'h4FFC, 32'h5004, 1'b1, 1'b1, 5'd0);

    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_2FFC, 32'h2442_0001);
    tick();
    check_all("below_lo", 32'h0, 32'h2FFC, 32'h3004, 1'b1, 1'b1, 5'd4);

    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h2442_0001);
    tick();
    check_all("wrap", 32'h0, 32'hFFFF_FFFC, 32'h0000_0004, 1'b1, 1'b0, 5'd4);

    // Flush beats stall.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_4180, 32'h8C43_0000);
    tick();
    check_all("flush_stall", 32'h0, 32'h4180, 32'h4188, 1'b0, 1'b0, 5'd0);

    // Flush also suppresses a fetch fault.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_5000, 32'h8C43_0000);
    tick();
    check_all("flush_adel", 32'h0, 32'h5000, 32'h5008, 1'b0, 1'b0, 5'd0);

    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_3010, 32'h0085_1020);
    tick();
`ifdef BRANCH_LIKELY_EN
    check_all("annul", 32'h0, 32'h3010, 32'h3018, 1'b0, 1'b0, 5'd0);
`else
    check_all("annul", 32'h0085_1020, 32'h3010, 32'h3018, 1'b1, 1'b1, 5'd0);
`endif

    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_3011, 32'h0085_1020);
    tick();
`ifdef BRANCH_LIKELY_EN
    check_all("annul_adel", 32'h0, 32'h3011, 32'h3019, 1'b0, 1'b0, 5'd0);
`else
    check_all("annul_adel", 32'h0, 32'h3011, 32'h3019, 1'b1, 1'b0, 5'd4);
`endif

    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_3014, 32'h03E0_0008);
    tick();
    check_all("pre_areset", 32'h03E0_0008, 32'h3014, 32'h301C, 1'b1, 1'b1, 5'd0);

    // Asynchronous reset mid-cycle; the next edge is still about 6 units away.
    #2;
    reset = 1'b1;
    #1;
    check_all("areset", 32'h0, 32'h3000, 32'h3008, 1'b0, 1'b0, 5'd0);
    tick();
    check_all("areset_hold", 32'h0, 32'h3000, 32'h3008, 1'b0, 1'b0, 5'd0);
    reset = 1'b0;

    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_3020, 32'h2108_FFFF);
    tick();
    check_all("post_reset", 32'h2108_FFFF, 32'h3020, 32'h3028, 1'b1, 1'b0, 5'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
